lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store controller between the execute stage and the 64-bit word-addressed data memory.
- Converts byte, half, word and doubleword requests into whole-dword memory accesses.
- Sub-dword stores use read-modify-write; requests that cross a dword boundary are split into two word operations.
- Loads return sign- or zero-extended data over a valid/ready handshake.

Parameters:
- MEM_WORDS, 1000: number of 64-bit words in the data memory. Valid word index is 0..MEM_WORDS-1.
- XLEN, 64: data and address width. Fixed at 64.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = B, 1 = H, 2 = W, 3 = D.
- req_unsigned  in  1  zero-extend load result. Ignored for D and for stores.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, low-order bytes used.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  64  load result. 0 for stores.
- resp_err  out  1  access out of range. Qualified by resp_valid.
- mem_A  out  64  byte address to memory. Always dword-aligned (low 3 bits = 0).
- mem_WD  out  64  write data to memory.
- mem_WE  out  1  memory write enable.
- mem_RD  in  64  combinational read data from memory.

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - mem_WE = 0, mem_A = 0, mem_WD = 0.
  - All internal buffers = 0.
- Definitions:
  - nbytes = 1 << req_size; off = addr[2:0]; w0 = addr[63:3].
  - span = (off + nbytes > 8); w1 = w0 + 1.
- Accept:
  - req_ready = (state == IDLE).
  - On req_valid && req_ready: latch the full request and compute span.
  - Set err = (w0 >= MEM_WORDS) || (span && w1 >= MEM_WORDS).
- State machine (one state per cycle):
  - IDLE: wait for accept. If err, go to RESP. Else if a store with off == 0 and size == D, go to WR_LO. Else go to RD_LO.
  - RD_LO: mem_A = w0 << 3; capture mem_RD into buf0. If span, go to RD_HI. Else a store goes to WR_LO and a load goes to RESP.
  - RD_HI: mem_A = w1 << 3; capture mem_RD into buf1. A store goes to WR_LO; a load goes to RESP.
  - WR_LO: mem_A = w0 << 3, mem_WE = 1. mem_WD = buf0 with bytes off..min(7, off+nbytes-1) replaced by the low store bytes. Go to WR_HI if span, else RESP.
  - WR_HI: mem_A = w1 << 3, mem_WE = 1. mem_WD = buf1 with bytes 0..(off+nbytes-9) replaced by the remaining store bytes. Go to RESP.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- Load data: resp_rdata = extend(({buf1, buf0} >> (8*off))[8*nbytes-1:0]).
  - Sign-extend unless req_unsigned; D is never extended.
  - resp_rdata is held until the next RESP.
- Error access: no memory read or write occurs, resp_rdata = 0, resp_err = 1.
- mem_WE is 0 in every state except WR_LO and WR_HI. mem_A = 0 in IDLE and RESP.
- Latency from the accept edge to resp_valid:
  - aligned/non-span load: 2 cycles.
  - span load: 3 cycles.
  - aligned D store: 2 cycles.
  - non-span sub-dword store: 3 cycles.
  - span store: 5 cycles.
  - error: 1 cycle.
- req_valid while busy is ignored; the core must hold the request until accepted.
- Back-to-back: a request can be accepted the cycle after RESP, since IDLE follows RESP.
- Reset during an operation aborts immediately; no further writes occur. For a span store reset after WR_LO, the low word stays written; this is accepted behaviour.
- Load data always comes from the read states, so there is no store-to-load forwarding hazard.

Decomposition:
- Package lsu_pkg:
  - size_e enum (SZ_B, SZ_H, SZ_W, SZ_D).
  - state_e enum (IDLE, RD_LO, RD_HI, WR_LO, WR_HI, RESP).
  - Function byte_mask(size, off) returning a 16-bit mask over {hi, lo}.
- Sub-module lsu_align (combinational), instantiated once:
  - Load path: extract and sign/zero-extend from {buf1, buf0}.
  - Store path: produce merged lo/hi write words from buffers, wdata, size and off.

Test Plan:
- Aligned D store: addr 0x40, wdata 0x1122334455667788. Expect WE for one cycle at mem_A 0x40, resp at +2, no read state. D load from 0x40 then returns 0x1122334455667788 at +2.
- Byte load sign/zero: word 0x40 = 0x00000000000080FF, load B addr 0x41 → 0xFFFFFFFFFFFFFF80. Same load with req_unsigned → 0x80. H load at 0x40 signed → 0xFFFFFFFFFFFF80FF.
- Sub-word RMW store: word 0x08 = 0xAAAAAAAAAAAAAAAA, store H 0xBEEF at 0x0A. Expect one write of 0xAAAAAAAABEEFAAAA at +2 and resp at +3.
- Span store/load: words 0x10 and 0x18 = 0. Store W 0xDEADBEEF at 0x16.
  - Word 0x10 becomes 0xBEEF000000000000; word 0x18 becomes 0x000000000000DEAD; resp at +5.
  - W load from 0x16 returns 0xFFFFFFFFDEADBEEF at +3.
- Range error: MEM_WORDS = 1000, store D at 999*8 + 4. The span exceeds the top word, so expect no mem_WE, resp_err = 1 at +1, and the contents of word 999 unchanged.
- Reset mid span store: assert rst in WR_HI. Expect immediate IDLE, req_ready = 1, mem_WE = 0, resp_valid never pulses, word w1 unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, controller
// states and the byte-lane mask used by the store merge.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    RESP  = 3'd5
  } state_e;

  // Byte lanes touched by an access, over the 16-byte window {hi, lo}.
  function automatic logic [15:0] byte_mask(size_e size, logic [2:0] off);
    logic [15:0] m;
    m = 16'h0001;
    case (size)
      SZ_B: m = 16'h0001;
      SZ_H: m = 16'h0003;
      SZ_W: m = 16'h000F;
      SZ_D: m = 16'h00FF;
      default: m = 16'h0001;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Data alignment for the LSU: extracts/extends load data from a dword pair and
// merges store bytes into the buffered low/high dwords.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [63:0] lo_i,
  input  logic [63:0] hi_i,
  input  logic [2:0]  off_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] ld_data_o,
  output logic [63:0] st_lo_o,
  output logic [63:0] st_hi_o
);

  logic [63:0]  sh;
  logic [15:0]  mask;
  logic [127:0] st_bytes;
  logic [127:0] merged;

  always_comb begin
    sh = 64'({hi_i, lo_i} >> {off_i, 3'b000});
    case (size_i)
      SZ_B:    ld_data_o = unsigned_i ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      SZ_H:    ld_data_o = unsigned_i ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      SZ_W:    ld_data_o = unsigned_i ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: ld_data_o = sh;
    endcase
  end

  // Store bytes are shifted into lane position; lanes outside the mask keep
  // whatever was read back from memory.
  always_comb begin
    mask     = byte_mask(size_i, off_i);
    st_bytes = {64'd0, wdata_i} << {off_i, 3'b000};
    merged   = {hi_i, lo_i};
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) merged[8*i +: 8] = st_bytes[8*i +: 8];
    end
  end

  assign st_lo_o = merged[63:0];
  assign st_hi_o = merged[127:64];

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: turns B/H/W/D requests into dword-aligned memory
// reads and writes, using read-modify-write and dword-pair splitting.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1000,
  parameter int XLEN      = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_A,
  output logic [XLEN-1:0] mem_WD,
  output logic            mem_WE,
  input  logic [XLEN-1:0] mem_RD
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  size_e       size_q, size_d;
  logic        uns_q, uns_d;
  logic [2:0]  off_q, off_d;
  logic [60:0] w0_q, w0_d;
  logic        span_q, span_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] buf0_q, buf0_d;
  logic [63:0] buf1_q, buf1_d;
  logic [63:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;

  logic        accept;
  logic [3:0]  nbytes;
  logic        span_in;
  logic        err_in;
  logic [63:0] lo_word, hi_word;
  logic [63:0] ld_data, st_lo, st_hi;
  logic [63:0] addr_lo, addr_hi;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;
  assign accept     = req_valid && req_ready;

  assign nbytes  = 4'd1 << req_size;
  assign span_in = ({1'b0, req_addr[2:0]} + nbytes) > 4'd8;
  assign err_in  = (64'(req_addr[63:3]) >= 64'(MEM_WORDS)) ||
                   (span_in && (64'(req_addr[63:3]) + 64'd1 >= 64'(MEM_WORDS)));

  assign addr_lo = {w0_q, 3'b000};
  assign addr_hi = {w0_q + 61'd1, 3'b000};

  // During a read state the word being captured is not yet in its buffer, so
  // the aligner sees it straight from memory; the load result is then ready
  // to register on the edge that enters RESP.
  assign lo_word = (state_q == RD_LO) ? mem_RD : buf0_q;
  assign hi_word = (state_q == RD_HI) ? mem_RD : buf1_q;

  lsu_align u_align (
    .lo_i       (lo_word),
    .hi_i       (hi_word),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .ld_data_o  (ld_data),
    .st_lo_o    (st_lo),
    .st_hi_o    (st_hi)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    w0_d    = w0_q;
    span_d  = span_q;
    wdata_d = wdata_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    mem_A   = 64'd0;
    mem_WD  = 64'd0;
    mem_WE  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          size_d  = size_e'(req_size);
          uns_d   = req_unsigned;
          off_d   = req_addr[2:0];
          w0_d    = req_addr[63:3];
          span_d  = span_in;
          wdata_d = req_wdata;
          if (err_in) begin
            rdata_d = 64'd0;
            rerr_d  = 1'b1;
            state_d = RESP;
          end else if (req_we && req_addr[2:0] == 3'd0 && size_e'(req_size) == SZ_D) begin
            state_d = WR_LO;
          end else begin
            state_d = RD_LO;
          end
        end
      end
      RD_LO: begin
        mem_A  = addr_lo;
        buf0_d = mem_RD;
        if (span_q)    state_d = RD_HI;
        else if (we_q) state_d = WR_LO;
        else begin
          rdata_d = ld_data;
          rerr_d  = 1'b0;
          state_d = RESP;
        end
      end
      RD_HI: begin
        mem_A  = addr_hi;
        buf1_d = mem_RD;
        if (we_q) state_d = WR_LO;
        else begin
          rdata_d = ld_data;
          rerr_d  = 1'b0;
          state_d = RESP;
        end
      end
      WR_LO: begin
        mem_A  = addr_lo;
        mem_WE = 1'b1;
        mem_WD = st_lo;
        if (span_q) state_d = WR_HI;
        else begin
          rdata_d = 64'd0;
          rerr_d  = 1'b0;
          state_d = RESP;
        end
      end
      WR_HI: begin
        mem_A   = addr_hi;
        mem_WE  = 1'b1;
        mem_WD  = st_hi;
        rdata_d = 64'd0;
        rerr_d  = 1'b0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from the same pre-edge snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the read buffers are cleared on reset too; they feed the load
      // and store datapaths and must never expose stale contents.
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      off_q   <= 3'd0;
      w0_q    <= 61'd0;
      span_q  <= 1'b0;
      wdata_q <= 64'd0;
      buf0_q  <= 64'd0;
      buf1_q  <= 64'd0;
      rdata_q <= 64'd0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      w0_q    <= w0_d;
      span_q  <= span_d;
      wdata_q <= wdata_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a 1000-dword memory model, a table of
// single requests with hand-computed results, and a mid-operation reset.
module tb_lsu_mem_ctrl;

  localparam int NWORDS  = 1000;
  localparam int TIMEOUT = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic [63:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;

  logic [63:0] mem [0:NWORDS-1] = '{default: 64'd0};
  logic        pre_en = 1'b0;
  logic [9:0]  pre_idx = 10'd0;
  logic [63:0] pre_val = 64'd0;
  int          oob_wr = 0;

  int n_pass = 0;
  int n_total = 0;
  int busy_ready = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.MEM_WORDS(NWORDS), .XLEN(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_A        (mem_a),
    .mem_WD       (mem_wd),
    .mem_WE       (mem_we),
    .mem_RD       (mem_rd)
  );

  assign mem_rd = (mem_a[63:3] < 61'd1000) ? mem[mem_a[12:3]] : 64'd0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_we) begin
      if (mem_a[63:3] < 61'd1000) mem[mem_a[12:3]] <= mem_wd;
      else oob_wr <= oob_wr + 1;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          lat;
    logic [63:0] rdata;
    logic        err;
    int          nwr;
    int          fwr;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic preload(input int idx, input logic [63:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = 10'(idx);
    pre_val = val;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  // Issue one request and watch until resp_valid; lat stays 0 on timeout.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        output int lat, output logic [63:0] rdata, output logic err,
                        output int nwr, output int fwr);
    lat = 0; nwr = 0; fwr = 0; rdata = 64'd0; err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge clk);
      if (req_ready) busy_ready++;
      if (mem_we) begin
        nwr++;
        if (fwr == 0) fwr = c;
      end
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
  endtask

  initial begin
    int          lat, nwr, fwr, pulses;
    logic [63:0] rdata;
    logic        err;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 64'd0; req_wdata = 64'd0;

    vecs[0]  = '{1'b1, 2'd3, 1'b0, 64'h40,   64'h1122334455667788, 2, 64'h0,                 1'b0, 1, 1};
    vecs[1]  = '{1'b0, 2'd3, 1'b0, 64'h40,   64'h0,                2, 64'h1122334455667788,  1'b0, 0, 0};
    vecs[2]  = '{1'b1, 2'd3, 1'b0, 64'h40,   64'h00000000000080FF, 2, 64'h0,                 1'b0, 1, 1};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 64'h41,   64'h0,                2, 64'hFFFFFFFFFFFFFF80,  1'b0, 0, 0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 64'h41,   64'h0,                2, 64'h80,                1'b0, 0, 0};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 64'h40,   64'h0,                2, 64'hFFFFFFFFFFFF80FF,  1'b0, 0, 0};
    vecs[6]  = '{1'b0, 2'd1, 1'b1, 64'h40,   64'h0,                2, 64'h80FF,              1'b0, 0, 0};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 64'h40,   64'h0,                2, 64'h80FF,              1'b0, 0, 0};
    vecs[8]  = '{1'b1, 2'd1, 1'b0, 64'h0A,   64'h123456789ABCBEEF, 3, 64'h0,                 1'b0, 1, 2};
    vecs[9]  = '{1'b0, 2'd3, 1'b0, 64'h08,   64'h0,                2, 64'hAAAAAAAABEEFAAAA,  1'b0, 0, 0};
    vecs[10] = '{1'b1, 2'd2, 1'b0, 64'h16,   64'hFFFFFFFFDEADBEEF, 5, 64'h0,                 1'b0, 2, 3};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 64'h16,   64'h0,                3, 64'hFFFFFFFFDEADBEEF,  1'b0, 0, 0};
    vecs[12] = '{1'b0, 2'd2, 1'b1, 64'h16,   64'h0,                3, 64'hDEADBEEF,          1'b0, 0, 0};
    vecs[13] = '{1'b0, 2'd3, 1'b1, 64'h12,   64'h0,                3, 64'hDEADBEEF00000000,  1'b0, 0, 0};
    vecs[14] = '{1'b1, 2'd3, 1'b0, 64'h1F3C, 64'hCAFEF00DCAFEF00D, 1, 64'h0,                 1'b1, 0, 0};
    vecs[15] = '{1'b0, 2'd0, 1'b0, 64'h1F40, 64'h0,                1, 64'h0,                 1'b1, 0, 0};
    vecs[16] = '{1'b0, 2'd0, 1'b1, 64'h1F3F, 64'h0,                2, 64'h01,                1'b0, 0, 0};
    vecs[17] = '{1'b0, 2'd1, 1'b0, 64'h1F3F, 64'h0,                1, 64'h0,                 1'b1, 0, 0};

    #2;
    check("reset req_ready",  64'(req_ready),  64'd1);
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset resp_rdata", resp_rdata,      64'd0);
    check("reset resp_err",   64'(resp_err),   64'd0);
    check("reset mem_WE",     64'(mem_we),     64'd0);
    check("reset mem_A",      mem_a,           64'd0);
    check("reset mem_WD",     mem_wd,          64'd0);
    @(negedge clk);
    rst = 1'b0;

    preload(1,   64'hAAAAAAAAAAAAAAAA);
    preload(999, 64'h0123456789ABCDEF);
    preload(5,   64'h5555555555555555);
    preload(6,   64'h6666666666666666);

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
             lat, rdata, err, nwr, fwr);
      check($sformatf("v%0d latency", i),     64'(lat),  64'(vecs[i].lat));
      check($sformatf("v%0d rdata", i),       rdata,     vecs[i].rdata);
      check($sformatf("v%0d err", i),         64'(err),  64'(vecs[i].err));
      check($sformatf("v%0d writes", i),      64'(nwr),  64'(vecs[i].nwr));
      check($sformatf("v%0d first write", i), 64'(fwr),  64'(vecs[i].fwr));
    end

    check("mem word 0x08 after RMW",  mem[1],   64'hAAAAAAAABEEFAAAA);
    check("mem word 0x10 after span", mem[2],   64'hBEEF000000000000);
    check("mem word 0x18 after span", mem[3],   64'h000000000000DEAD);
    check("mem word 0x40 final",      mem[8],   64'h00000000000080FF);
    check("mem word 999 untouched",   mem[999], 64'h0123456789ABCDEF);
    check("ready while busy",         64'(busy_ready), 64'd0);

    // Span store to 0x2E, reset asserted while in WR_HI.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 64'h2E; req_wdata = 64'h00000000DEADBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("wr_hi mem_WE", 64'(mem_we), 64'd1);
    check("wr_hi mem_A",  mem_a,       64'h30);
    rst = 1'b1;
    #1;
    check("abort req_ready",  64'(req_ready),  64'd1);
    check("abort mem_WE",     64'(mem_we),     64'd0);
    check("abort mem_A",      mem_a,           64'd0);
    check("abort resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("abort resp pulses",     64'(pulses), 64'd0);
    check("abort low word written", mem[5],     64'hBEEF555555555555);
    check("abort high word intact", mem[6],     64'h6666666666666666);

    // Back-to-back loads after the abort.
    do_req(1'b0, 2'd3, 1'b0, 64'h30, 64'd0, lat, rdata, err, nwr, fwr);
    check("post-abort load latency", 64'(lat), 64'd2);
    check("post-abort load rdata",   rdata,    64'h6666666666666666);
    do_req(1'b0, 2'd0, 1'b0, 64'h2F, 64'd0, lat, rdata, err, nwr, fwr);
    check("b2b byte load latency",   64'(lat), 64'd2);
    check("b2b byte load rdata",     rdata,    64'hFFFFFFFFFFFFFFBE);
    check("out-of-range writes",     64'(oob_wr), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
